// File: rtl/jk_excitation_driver_pkg.sv
// Shared definitions for the JK excitation driver: FSM encodings, don't-care
// policies and the per-bit JK excitation function.
package jk_excitation_driver_pkg;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_LOAD  = 2'd1;
   localparam logic [1:0] ST_DRIVE = 2'd2;
   localparam logic [1:0] ST_CHECK = 2'd3;

   localparam int DC_HOLD   = 0;
   localparam int DC_TOGGLE = 1;

   // Returns {j, k} that moves one flip-flop from q to t; x fills the don't-care.
   function automatic logic [1:0] jk_excite(input logic q, input logic t, input logic x);
      logic [1:0] jk;
      case ({q, t})
         2'b00:   jk = {1'b0, x};
         2'b01:   jk = {1'b1, x};
         2'b10:   jk = {x, 1'b1};
         2'b11:   jk = {x, 1'b0};
         default: jk = 2'b00;
      endcase
      return jk;
   endfunction

endpackage

// File: rtl/jk_excitation_driver_if.sv
// Target stream, bank feedback and status bundle between a pattern source and
// the excitation driver.
interface jk_excitation_driver_if #(parameter int WIDTH = 4);

   logic             TGT_VALID;
   logic             TGT_READY;
   logic [WIDTH-1:0] TGT_DATA;
   logic [WIDTH-1:0] Q_IN;
   logic [WIDTH-1:0] J;
   logic [WIDTH-1:0] K;
   logic             EXC_VALID;
   logic             MISMATCH;
   logic [7:0]       ERR_CNT;
   logic             BUSY;

   modport master (
      output TGT_VALID, TGT_DATA, Q_IN,
      input  TGT_READY, J, K, EXC_VALID, MISMATCH, ERR_CNT, BUSY
   );

   modport slave (
      input  TGT_VALID, TGT_DATA, Q_IN,
      output TGT_READY, J, K, EXC_VALID, MISMATCH, ERR_CNT, BUSY
   );

endinterface

// File: rtl/jk_target_fifo.sv
// Synchronous target FIFO; a push while full is taken only when a pop frees
// the head slot in the same cycle. Reads as zero when empty.
module jk_target_fifo #(
   parameter int WIDTH = 4,
   parameter int DEPTH = 4
) (
   input  logic                     CLK,
   input  logic                     RST,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         din,
   output logic [WIDTH-1:0]         dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem_r [DEPTH];
   logic [AW-1:0]    wr_ptr_r;
   logic [AW-1:0]    rd_ptr_r;
   logic [CW-1:0]    count_r;
   logic             push_s;
   logic             pop_s;

   assign empty  = (count_r == {CW{1'b0}});
   assign full   = (count_r == CW'(DEPTH));
   assign count  = count_r;
   assign pop_s  = pop & ~empty;
   assign push_s = push & (~full | pop_s);
   assign dout   = empty ? {WIDTH{1'b0}} : mem_r[rd_ptr_r];

   // Pointer and occupancy bookkeeping; power-of-two depth lets pointers wrap naturally.
   always_ff @(posedge CLK) begin
      if (RST) begin
         wr_ptr_r <= {AW{1'b0}};
         rd_ptr_r <= {AW{1'b0}};
         count_r  <= {CW{1'b0}};
      end else begin
         if (push_s) wr_ptr_r <= wr_ptr_r + AW'(1);
         if (pop_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
         case ({push_s, pop_s})
            2'b10:   count_r <= count_r + CW'(1);
            2'b01:   count_r <= count_r - CW'(1);
            default: count_r <= count_r;
         endcase
      end
   end

   // Storage write.
   always_ff @(posedge CLK) begin
      if (push_s) mem_r[wr_ptr_r] <= din;
   end

endmodule

// File: rtl/jk_excitation_driver.sv
// Derives J/K excitation from queued target words, drives the external JK bank
// for one cycle, then checks the bank reached the target.
module jk_excitation_driver
   import jk_excitation_driver_pkg::*;
#(
   parameter int WIDTH     = 4,
   parameter int DEPTH     = 4,
   parameter int DC_POLICY = 0
) (
   input  logic                   CLK,
   input  logic                   RST,
   jk_excitation_driver_if.slave  bus
);

   localparam logic DC_X = (DC_POLICY == DC_TOGGLE) ? 1'b1 : 1'b0;

   logic [1:0]         state_r;
   logic [WIDTH-1:0]   tgt_r;
   logic [WIDTH-1:0]   j_r;
   logic [WIDTH-1:0]   k_r;
   logic               exc_valid_r;
   logic               mismatch_r;
   logic [7:0]         err_cnt_r;

   logic               fifo_push_s;
   logic               fifo_pop_s;
   logic [WIDTH-1:0]   fifo_dout_s;
   logic               fifo_full_s;
   logic               fifo_empty_s;
   logic [$clog2(DEPTH):0] fifo_count_s;
   logic [WIDTH-1:0]   exc_j_s;
   logic [WIDTH-1:0]   exc_k_s;

   assign fifo_push_s = bus.TGT_VALID & ~fifo_full_s;

   jk_target_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
      .CLK   (CLK),
      .RST   (RST),
      .push  (fifo_push_s),
      .pop   (fifo_pop_s),
      .din   (bus.TGT_DATA),
      .dout  (fifo_dout_s),
      .full  (fifo_full_s),
      .empty (fifo_empty_s),
      .count (fifo_count_s)
   );

   // Head of queue is consumed when leaving IDLE or when CHECK chains to the next word.
   always_comb begin
      fifo_pop_s = 1'b0;
      case (state_r)
         ST_IDLE:  fifo_pop_s = ~fifo_empty_s;
         ST_CHECK: fifo_pop_s = ~fifo_empty_s;
         default:  fifo_pop_s = 1'b0;
      endcase
   end

   // Per-bit excitation from the present bank state towards the held target.
   always_comb begin
      exc_j_s = {WIDTH{1'b0}};
      exc_k_s = {WIDTH{1'b0}};
      for (int i = 0; i < WIDTH; i++) begin
         {exc_j_s[i], exc_k_s[i]} = jk_excite(bus.Q_IN[i], tgt_r[i], DC_X);
      end
   end

   // Sequencer: J/K are nonzero only while EXC_VALID is high (the DRIVE cycle).
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_r     <= ST_IDLE;
         tgt_r       <= {WIDTH{1'b0}};
         j_r         <= {WIDTH{1'b0}};
         k_r         <= {WIDTH{1'b0}};
         exc_valid_r <= 1'b0;
         mismatch_r  <= 1'b0;
         err_cnt_r   <= 8'd0;
      end else begin
         mismatch_r <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               j_r         <= {WIDTH{1'b0}};
               k_r         <= {WIDTH{1'b0}};
               exc_valid_r <= 1'b0;
               if (!fifo_empty_s) begin
                  tgt_r   <= fifo_dout_s;
                  state_r <= ST_LOAD;
               end else begin
                  state_r <= ST_IDLE;
               end
            end
            ST_LOAD: begin
               j_r         <= exc_j_s;
               k_r         <= exc_k_s;
               exc_valid_r <= 1'b1;
               state_r     <= ST_DRIVE;
            end
            ST_DRIVE: begin
               j_r         <= {WIDTH{1'b0}};
               k_r         <= {WIDTH{1'b0}};
               exc_valid_r <= 1'b0;
               state_r     <= ST_CHECK;
            end
            ST_CHECK: begin
               if (bus.Q_IN != tgt_r) begin
                  mismatch_r <= 1'b1;
                  if (err_cnt_r != 8'd255) err_cnt_r <= err_cnt_r + 8'd1;
               end
               if (!fifo_empty_s) begin
                  tgt_r   <= fifo_dout_s;
                  state_r <= ST_LOAD;
               end else begin
                  state_r <= ST_IDLE;
               end
            end
            default: begin
               j_r         <= {WIDTH{1'b0}};
               k_r         <= {WIDTH{1'b0}};
               exc_valid_r <= 1'b0;
               state_r     <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.TGT_READY = ~fifo_full_s;
   assign bus.J         = j_r;
   assign bus.K         = k_r;
   assign bus.EXC_VALID = exc_valid_r;
   assign bus.MISMATCH  = mismatch_r;
   assign bus.ERR_CNT   = err_cnt_r;
   assign bus.BUSY      = (state_r != ST_IDLE) | ~fifo_empty_s;

endmodule

// File: tb/tb_jk_excitation_driver.sv
// Closed-loop bench: two drivers (hold and toggle don't-care policies) each
// steering a behavioural JK bank, plus a standalone target FIFO.
module tb_jk_excitation_driver;

   logic CLK = 1'b0;
   logic RST = 1'b1;
   always #5 CLK = ~CLK;

   jk_excitation_driver_if #(.WIDTH(4)) if0 ();
   jk_excitation_driver_if #(.WIDTH(4)) if1 ();

   jk_excitation_driver #(.WIDTH(4), .DEPTH(4), .DC_POLICY(0)) u0 (.CLK(CLK), .RST(RST), .bus(if0));
   jk_excitation_driver #(.WIDTH(4), .DEPTH(4), .DC_POLICY(1)) u1 (.CLK(CLK), .RST(RST), .bus(if1));

   logic [3:0] bank0 = 4'b0000;
   logic [3:0] bank1 = 4'b0000;
   logic [3:0] stuck0 = 4'b0000;
   assign if0.Q_IN = bank0;
   assign if1.Q_IN = bank1;

   // JK flip-flop banks: Q+ = J&~Q | ~K&Q, with optional stuck-at-0 bits on bank 0.
   always @(posedge CLK) begin
      bank0 <= ((if0.J & ~bank0) | (~if0.K & bank0)) & ~stuck0;
      bank1 <= (if1.J & ~bank1) | (~if1.K & bank1);
   end

   logic       f_rst, f_push, f_pop, f_full, f_empty;
   logic [3:0] f_din, f_dout;
   logic [2:0] f_count;
   jk_target_fifo #(.WIDTH(4), .DEPTH(4)) f6 (
      .CLK(CLK), .RST(f_rst), .push(f_push), .pop(f_pop), .din(f_din),
      .dout(f_dout), .full(f_full), .empty(f_empty), .count(f_count)
   );

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   typedef struct {
      int         sel;
      logic [3:0] tgt;
      logic [3:0] ej;
      logic [3:0] ek;
      logic [3:0] eq;
   } vec_t;
   vec_t vt [7];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
      cyc++;
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      logic ok;
      logic [3:0] jv, kv, qv;
      logic mm;
      if (v.sel == 0) begin if0.TGT_VALID = 1'b1; if0.TGT_DATA = v.tgt; end
      else            begin if1.TGT_VALID = 1'b1; if1.TGT_DATA = v.tgt; end
      tick();
      if0.TGT_VALID = 1'b0;
      if1.TGT_VALID = 1'b0;
      ok = 1'b0;
      for (int n = 0; n < 10 && !ok; n++) begin
         if ((v.sel == 0) ? if0.EXC_VALID : if1.EXC_VALID) ok = 1'b1;
         else tick();
      end
      chk($sformatf("vec%0d_exc_seen", idx), 32'(ok), 32'd1);
      jv = (v.sel == 0) ? if0.J : if1.J;
      kv = (v.sel == 0) ? if0.K : if1.K;
      chk($sformatf("vec%0d_J", idx), 32'(jv), 32'(v.ej));
      chk($sformatf("vec%0d_K", idx), 32'(kv), 32'(v.ek));
      tick();
      jv = (v.sel == 0) ? if0.J : if1.J;
      kv = (v.sel == 0) ? if0.K : if1.K;
      qv = (v.sel == 0) ? bank0 : bank1;
      chk($sformatf("vec%0d_JK_idle", idx), 32'({jv, kv}), 32'd0);
      chk($sformatf("vec%0d_bank", idx), 32'(qv), 32'(v.eq));
      tick();
      mm = (v.sel == 0) ? if0.MISMATCH : if1.MISMATCH;
      chk($sformatf("vec%0d_mismatch", idx), 32'(mm), 32'd0);
   endtask

   task automatic wait_idle0(input string name);
      logic done;
      done = 1'b0;
      for (int n = 0; n < 60 && !done; n++) begin
         if (!if0.BUSY) done = 1'b1;
         else tick();
      end
      chk(name, 32'(done), 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int pulses [$];
      int acc, rej, sent, mm, bad;
      logic r;
      logic [3:0] w3 [4];
      logic [3:0] wf [6];
      logic [3:0] saved;
      logic [3:0] fexp [4];

      // Policy 0 (x=0) on driver 0, then policy 1 (x=1) on driver 1.
      vt[0] = '{0, 4'b1010, 4'b1010, 4'b0000, 4'b1010};
      vt[1] = '{0, 4'b0110, 4'b0100, 4'b1000, 4'b0110};
      vt[2] = '{0, 4'b1001, 4'b1001, 4'b0110, 4'b1001};
      vt[3] = '{0, 4'b1001, 4'b0000, 4'b0000, 4'b1001};
      vt[4] = '{0, 4'b0000, 4'b0000, 4'b1001, 4'b0000};
      vt[5] = '{1, 4'b1010, 4'b1010, 4'b1111, 4'b1010};
      vt[6] = '{1, 4'b0110, 4'b1110, 4'b1101, 4'b0110};

      if0.TGT_VALID = 1'b0; if0.TGT_DATA = 4'b0000;
      if1.TGT_VALID = 1'b0; if1.TGT_DATA = 4'b0000;
      f_rst = 1'b1; f_push = 1'b0; f_pop = 1'b0; f_din = 4'b0000;

      RST = 1'b1;
      tick();
      tick();
      RST = 1'b0;
      chk("rst_J", 32'(if0.J), 32'd0);
      chk("rst_K", 32'(if0.K), 32'd0);
      chk("rst_exc_valid", 32'(if0.EXC_VALID), 32'd0);
      chk("rst_mismatch", 32'(if0.MISMATCH), 32'd0);
      chk("rst_err_cnt", 32'(if0.ERR_CNT), 32'd0);
      chk("rst_busy", 32'(if0.BUSY), 32'd0);
      chk("rst_ready", 32'(if0.TGT_READY), 32'd1);

      for (int i = 0; i < 7; i++) run_vec(vt[i], i);

      // Four targets back-to-back: one excitation every third cycle.
      w3[0] = 4'b0001; w3[1] = 4'b0011; w3[2] = 4'b0111; w3[3] = 4'b1111;
      for (int i = 0; i < 4; i++) begin
         if0.TGT_VALID = 1'b1;
         if0.TGT_DATA  = w3[i];
         chk($sformatf("t3_ready%0d", i), 32'(if0.TGT_READY), 32'd1);
         tick();
         if (if0.EXC_VALID) pulses.push_back(cyc);
      end
      if0.TGT_VALID = 1'b0;
      for (int n = 0; n < 20; n++) begin
         tick();
         if (if0.EXC_VALID) pulses.push_back(cyc);
      end
      chk("t3_pulse_count", 32'(pulses.size()), 32'd4);
      for (int i = 1; i < pulses.size(); i++)
         chk($sformatf("t3_spacing%0d", i), 32'(pulses[i] - pulses[i-1]), 32'd3);
      chk("t3_bank", 32'(bank0), 32'b1111);
      chk("t3_err_cnt", 32'(if0.ERR_CNT), 32'd0);

      // Continuous offer: queue fills after the sixth accepted word.
      wf[0] = 4'b1110; wf[1] = 4'b1100; wf[2] = 4'b1000;
      wf[3] = 4'b0000; wf[4] = 4'b0001; wf[5] = 4'b0011;
      acc = 0; rej = 0;
      for (int n = 0; n < 20 && acc < 6; n++) begin
         if0.TGT_VALID = 1'b1;
         if0.TGT_DATA  = wf[acc];
         r = if0.TGT_READY;
         tick();
         if (r) acc++; else rej++;
      end
      if0.TGT_VALID = 1'b0;
      chk("fill_rejected", 32'(rej), 32'd0);
      chk("fill_ready_low", 32'(if0.TGT_READY), 32'd0);
      chk("fill_busy", 32'(if0.BUSY), 32'd1);
      wait_idle0("fill_drain");
      chk("fill_bank", 32'(bank0), 32'b0011);
      chk("fill_err_cnt", 32'(if0.ERR_CNT), 32'd0);

      // Stuck bit: one mismatch per unreachable target, count saturates.
      stuck0 = 4'b0001;
      tick();
      if0.TGT_VALID = 1'b1; if0.TGT_DATA = 4'b1111;
      tick();
      if0.TGT_VALID = 1'b0;
      mm = 0;
      for (int n = 0; n < 10; n++) begin
         tick();
         if (if0.MISMATCH) mm++;
      end
      chk("stuck_pulses", 32'(mm), 32'd1);
      chk("stuck_err_cnt1", 32'(if0.ERR_CNT), 32'd1);
      sent = 0;
      for (int n = 0; n < 3000 && sent < 299; n++) begin
         if0.TGT_VALID = 1'b1;
         if0.TGT_DATA  = 4'b1111;
         r = if0.TGT_READY;
         tick();
         if (r) sent++;
      end
      if0.TGT_VALID = 1'b0;
      chk("stuck_sent", 32'(sent), 32'd299);
      wait_idle0("stuck_drain");
      chk("stuck_err_cnt_sat", 32'(if0.ERR_CNT), 32'd255);
      stuck0 = 4'b0000;
      tick();

      // Reset during DRIVE with two words still queued.
      w3[0] = 4'b0101; w3[1] = 4'b0110; w3[2] = 4'b0111;
      for (int i = 0; i < 3; i++) begin
         if0.TGT_VALID = 1'b1;
         if0.TGT_DATA  = w3[i];
         tick();
      end
      if0.TGT_VALID = 1'b0;
      chk("abort_in_drive", 32'(if0.EXC_VALID), 32'd1);
      RST = 1'b1;
      tick();
      RST = 1'b0;
      chk("abort_JK", 32'({if0.J, if0.K}), 32'd0);
      chk("abort_busy", 32'(if0.BUSY), 32'd0);
      chk("abort_exc_valid", 32'(if0.EXC_VALID), 32'd0);
      chk("abort_ready", 32'(if0.TGT_READY), 32'd1);
      chk("abort_err_cnt", 32'(if0.ERR_CNT), 32'd0);
      saved = bank0;
      bad = 0;
      for (int n = 0; n < 6; n++) begin
         if (if0.MISMATCH || if0.EXC_VALID || if0.BUSY) bad++;
         tick();
      end
      chk("abort_quiet", 32'(bad), 32'd0);
      chk("abort_bank_hold", 32'(bank0), 32'(saved));

      // Standalone FIFO: full push ignored, push+pop while full keeps count and order.
      tick();
      f_rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         f_push = 1'b1;
         f_din  = 4'hA + 4'(i);
         tick();
      end
      chk("fifo_full", 32'(f_full), 32'd1);
      chk("fifo_count_full", 32'(f_count), 32'd4);
      f_din = 4'hF;
      tick();
      chk("fifo_push_when_full", 32'(f_count), 32'd4);
      f_din = 4'hE;
      f_pop = 1'b1;
      chk("fifo_head_before", 32'(f_dout), 32'hA);
      tick();
      f_push = 1'b0;
      chk("fifo_count_pushpop", 32'(f_count), 32'd4);
      fexp[0] = 4'hB; fexp[1] = 4'hC; fexp[2] = 4'hD; fexp[3] = 4'hE;
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("fifo_order%0d", i), 32'(f_dout), 32'(fexp[i]));
         tick();
      end
      f_pop = 1'b0;
      chk("fifo_empty", 32'(f_empty), 32'd1);
      chk("fifo_empty_dout", 32'(f_dout), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
